// File: rtl/hilo_muldiv_unit_pkg.sv
// ============================================================================
// Module   : hilo_muldiv_unit_pkg
// Brief    : Shared op encodings, word width and default latencies for the
//            HI/LO multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hilo_muldiv_unit_pkg;

    localparam int c_WORD_W         = 32;
    localparam int c_MUL_CYCLES_DEF = 5;
    localparam int c_DIV_CYCLES_DEF = 10;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_muldiv_unit_compute.sv
// ============================================================================
// Module   : muldiv_compute
// Brief    : Combinational 64-bit {HI,LO} result for MULT/MULTU/DIV/DIVU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_compute
    import hilo_muldiv_unit_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    output logic [63:0] o_result
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_safe_b;
    logic [31:0] w_safe_abs_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic        w_div_zero;
    logic        w_div_ovf;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign w_prod_s = {{32{i_src_a[31]}}, i_src_a} * {{32{i_src_b[31]}}, i_src_b};
    assign w_prod_u = {32'd0, i_src_a} * {32'd0, i_src_b};

    assign w_abs_a      = i_src_a[31] ? (32'd0 - i_src_a) : i_src_a;
    assign w_abs_b      = i_src_b[31] ? (32'd0 - i_src_b) : i_src_b;
    assign w_div_zero   = (i_src_b == 32'd0);
    assign w_div_ovf    = (i_src_a == 32'h8000_0000) && (i_src_b == 32'hFFFF_FFFF);
    assign w_safe_b     = w_div_zero ? 32'd1 : i_src_b;
    assign w_safe_abs_b = w_div_zero ? 32'd1 : w_abs_b;

    assign w_uq = i_src_a / w_safe_b;
    assign w_ur = i_src_a % w_safe_b;

    // Signed divide on magnitudes: quotient sign from a^b, remainder from a.
    assign w_sq = (i_src_a[31] ^ i_src_b[31]) ? (32'd0 - (w_abs_a / w_safe_abs_b))
                                               : (w_abs_a / w_safe_abs_b);
    assign w_sr = i_src_a[31] ? (32'd0 - (w_abs_a % w_safe_abs_b))
                              : (w_abs_a % w_safe_abs_b);

    always_comb begin
        o_result = 64'd0;
        case (i_op)
            MD_MULT:  o_result = w_prod_s;
            MD_MULTU: o_result = w_prod_u;
            MD_DIV: begin
                if (w_div_zero)     o_result = {i_src_a, 32'hFFFF_FFFF};
                else if (w_div_ovf) o_result = {32'd0, 32'h8000_0000};
                else                o_result = {w_sr, w_sq};
            end
            MD_DIVU: begin
                if (w_div_zero) o_result = {i_src_a, 32'hFFFF_FFFF};
                else            o_result = {w_ur, w_uq};
            end
            default:  o_result = 64'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
// ============================================================================
// Module   : hilo_muldiv_unit
// Brief    : Multi-cycle multiply/divide unit owning the HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int MUL_CYCLES = c_MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = c_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam int c_MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES);

    md_state_e          r_state;
    md_state_e          w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_p_hi;
    logic [31:0]        r_p_lo;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_busy;
    logic [63:0]        w_result;
    logic               w_accept;
    logic               w_done;

    muldiv_compute u_compute (
        .i_op     (op),
        .i_src_a  (src_a),
        .i_src_b  (src_b),
        .o_result (w_result)
    );

    assign w_accept = (r_state == ST_IDLE) && start && (is_mul_op(op) || is_div_op(op));
    assign w_done   = (r_state == ST_RUN) && (r_cnt == c_CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_RUN;
            ST_RUN:  if (w_done)   w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_p_hi <= '0;
            r_p_lo <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_RUN);
            if (r_state == ST_RUN) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
                if (w_done) begin
                    r_hi <= r_p_hi;
                    r_lo <= r_p_lo;
                end
            end else if (start) begin
                // Requests arriving while RUN never reach this branch.
                if (w_accept) begin
                    r_p_hi <= w_result[63:32];
                    r_p_lo <= w_result[31:0];
                    r_cnt  <= is_mul_op(op) ? c_MUL_LOAD : c_DIV_LOAD;
                end else if (op == MD_MTHI) begin
                    r_hi <= src_a;
                end else if (op == MD_MTLO) begin
                    r_lo <= src_a;
                end
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
// ============================================================================
// Module   : tb_hilo_muldiv_unit
// Brief    : Directed self-checking bench with a behavioural HI/LO model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int errs   = 0;
    int checks = 0;

    hilo_muldiv_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural result from plain SV arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int     q;
        int     r;
        case (o)
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_left;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_pend <= 64'd0;
            m_left <= 0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (start) begin
            if (op >= 3'd1 && op <= 3'd4) begin
                m_pend <= ref_result(op, src_a, src_b);
                m_left <= (op <= 3'd2) ? 5 : 10;
            end else if (op == 3'd5) begin
                m_hi <= src_a;
            end else if (op == 3'd6) begin
                m_lo <= src_a;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            check("model_hi", hi, m_hi);
            check("model_lo", lo, m_lo);
            check("model_busy", {31'd0, busy}, {31'd0, (m_left != 0)});
        end
    end

    // Entered and left on a falling edge; returns the number of busy cycles.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        run_op(3'd5, 32'h1234_5678, 32'd0, n);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_nobusy", n, 0);
        run_op(3'd6, 32'h9ABC_DEF0, 32'd0, n);
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mtlo_hi_kept", hi, 32'h1234_5678);
        check("mtlo_nobusy", n, 0);

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, n);
        check("mult_cycles", n, 5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        run_op(3'd2, 32'hFFFF_FFFE, 32'd3, n);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
        check("div_cycles", n, 10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(3'd4, 32'd7, 32'd2, n);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);

        run_op(3'd4, 32'd5, 32'd0, n);
        check("divz_cycles", n, 10);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'd5);

        // Requests during RUN must be dropped.
        start = 1'b1; op = 3'd1; src_a = 32'd7; src_b = 32'd6;
        @(negedge clk);
        op = 3'd6; src_a = 32'h0000_DEAD;
        @(negedge clk);
        check("run_ignore_lo", lo, 32'hFFFF_FFFF);
        op = 3'd3; src_a = 32'd100; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        check("run_ignore_hi", hi, 32'd5);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("run_busy_left", n, 3);
        check("run_final_hi", hi, 32'd0);
        check("run_final_lo", lo, 32'd42);

        run_op(3'd1, 32'h0001_0000, 32'h0001_0000, n);
        check("b2b_cycles", n, 5);
        check("b2b_hi", hi, 32'd1);
        check("b2b_lo", lo, 32'd0);

        start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multi-cycle multiply/divide unit owning the HI and LO architectural registers. It accepts operands from the execute stage, computes results over a fixed number of cycles, and exposes HI/LO to the execute-stage MFHI/MFLO result mux. It drives `busy` so hazard logic can stall dependent HI/LO instructions.

## Interface
- `MUL_CYCLES`, default 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (≥1).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request valid this cycle; `op` is sampled when high.
- `op` in 3: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `src_a` in 32: rs operand (dividend / multiplicand / MTHI/MTLO data).
- `src_b` in 32: rt operand (divisor / multiplier).
- `hi` out 32: architectural HI.
- `lo` out 32: architectural LO.
- `busy` out 1: operation in flight.

## Operation
- States: IDLE, RUN.
- IDLE with `start` and MULT/MULTU/DIV/DIVU:
  - latch the full result into pending registers `p_hi`/`p_lo`;
  - load the counter with MUL_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE with `start` and MTHI/MTLO: write `src_a` to HI/LO at that edge; stay in IDLE; `busy` stays low.
- RUN: decrement the counter each cycle. On the edge where the counter reaches 0:
  - HI←`p_hi`, LO←`p_lo`;
  - return to IDLE.
- `start` during RUN is ignored for every op, including MTHI/MTLO. Hazard logic must stall the requester.
- Arithmetic:
  - MULT: signed 32×32→64, {HI,LO}.
  - MULTU: unsigned 32×32→64, {HI,LO}.
  - DIV: signed. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - DIVU: unsigned. LO=quotient, HI=remainder.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero, signed or unsigned: LO=0xFFFFFFFF, HI=`src_a`. The full latency still applies.
- HI/LO keep their old values for the whole of RUN. Results become visible only at completion.
- Reset at any time, including mid-RUN: HI=0, LO=0, `busy`=0, state IDLE, counter 0, pending registers 0. The in-flight op is discarded.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0.
- Accepted start at edge T: `busy`=1 from after T through the cycle before edge T+N (N = op latency). `hi`/`lo` update at edge T+N, and `busy` falls at the same edge.
- Back-to-back: a `start` in the first cycle after `busy` falls is accepted.
- MTHI/MTLO: zero-latency register write at the sampling edge; visible next cycle.
- `hi`/`lo` are pure register outputs with no combinational path from inputs.
- `busy` is a register output.

## Structure
- Shared header holds:
  - op encodings (`MD_NONE`…`MD_MTLO`);
  - default latency constants;
  - the word width macro.
- One natural sub-module, `muldiv_compute`: combinational 64-bit product and quotient/remainder from (`op`, `src_a`, `src_b`), including the signed-overflow and divide-by-zero rules.
- The top holds the FSM, counter, pending registers and HI/LO.

## Test plan
- Reset then idle → `hi`=`lo`=0, `busy`=0. MTHI 0x12345678 then MTLO 0x9ABCDEF0 → `hi`=0x12345678, `lo`=0x9ABCDEF0 one cycle after each write; `busy` never rises.
- MULT 0xFFFFFFFE × 3 → `busy` high exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF after 10 busy cycles. DIVU 7 / 2 → `lo`=3, `hi`=1. DIV 0x80000000 / −1 → `lo`=0x80000000, `hi`=0.
- DIVU 5 / 0 → after 10 cycles `lo`=0xFFFFFFFF, `hi`=5.
- MULT in flight, then MTLO 0xDEAD and DIV asserted during RUN → both ignored. HI/LO unchanged until completion, then hold the MULT result. A MULT started in the cycle after `busy` falls is accepted.
- Assert `reset` in cycle 3 of a DIV → `busy`=0 and `hi`=`lo`=0 immediately (asynchronous). No later writeback of the aborted DIV.
